// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } deb_state_t;

    function automatic logic [4:0] snap_popcount(input logic [NUM_KEYS-1:0] snap);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {4'd0, snap[i]};
        end
        return n;
    endfunction

    // Snapshot bits are ordered col*4+row; key codes are row*4+col.
    function automatic key_code_t snap_to_code(input logic [NUM_KEYS-1:0] snap);
        logic [3:0] bit_idx;
        bit_idx = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                bit_idx = 4'(i);
            end
        end
        return {bit_idx[1:0], bit_idx[3:2]};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterised-width two-flop synchroniser; resets to all ones (idle rows).
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_r;
    logic [WIDTH-1:0] stage2_r;

    // Two-stage metastability filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_r <= {WIDTH{1'b1}};
            stage2_r <= {WIDTH{1'b1}};
        end else begin
            stage1_r <= d;
            stage2_r <= stage1_r;
        end
    end

    assign q = stage2_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame-level classification and debounce.
// Emits a one-cycle key_valid pulse when a single key has been stable long enough.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 256,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic      key_valid,
    output key_code_t key_code,
    output logic      key_held
);

    localparam int SLOT_W = $clog2(SCAN_CYCLES);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam bit DIRECT_HELD = (DEBOUNCE_FRAMES == 1);

    logic [3:0]          rows_sync_s;
    logic [SLOT_W-1:0]   slot_cnt_r;
    logic [1:0]          col_idx_r;
    logic [3:0]          col_n_r;
    logic [NUM_KEYS-1:0] snapshot_r;
    logic [NUM_KEYS-1:0] frame_snap_s;
    logic                slot_end_s;
    logic                frame_end_s;
    logic                present_s;
    key_code_t           cand_s;
    deb_state_t          state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    key_code_t           cand_r, cand_nxt_s;
    logic                accept_s;
    logic                key_valid_r;
    key_code_t           key_code_r;
    logic                key_held_r;

    sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (rows_sync_s)
    );

    assign slot_end_s  = (slot_cnt_r == SLOT_LAST);
    assign frame_end_s = slot_end_s && (col_idx_r == 2'd3);

    // Snapshot as it will look once the current column's rows are merged in.
    always_comb begin
        frame_snap_s = snapshot_r;
        frame_snap_s[{col_idx_r, 2'b00} +: 4] = ~rows_sync_s;
    end

    assign present_s = (snap_popcount(frame_snap_s) == 5'd1);
    assign cand_s    = snap_to_code(frame_snap_s);

    // Slot counter, column rotation and per-frame snapshot capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            col_idx_r  <= 2'd0;
            col_n_r    <= 4'b1110;
            snapshot_r <= {NUM_KEYS{1'b0}};
        end else begin
            if (slot_end_s) begin
                slot_cnt_r <= {SLOT_W{1'b0}};
                col_idx_r  <= col_idx_r + 2'd1;
                col_n_r    <= {col_n_r[2:0], col_n_r[3]};
                snapshot_r <= frame_end_s ? {NUM_KEYS{1'b0}} : frame_snap_s;
            end else begin
                slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
            end
        end
    end

    // Debounce next-state logic, advanced only at frame end.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cand_nxt_s  = cand_r;
        accept_s    = 1'b0;
        if (frame_end_s) begin
            case (state_r)
                IDLE, HELD: begin
                    if (!present_s) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else if ((state_r == HELD) && (cand_s == cand_r)) begin
                        state_nxt_s = HELD;
                    end else begin
                        cand_nxt_s  = cand_s;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = DIRECT_HELD ? HELD : COUNT;
                        accept_s    = DIRECT_HELD;
                    end
                end
                COUNT: begin
                    if (!present_s) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else if (cand_s == cand_r) begin
                        cnt_nxt_s = (cnt_r == CNT_TARGET) ? cnt_r : cnt_r + CNT_ONE;
                        if (cnt_nxt_s == CNT_TARGET) begin
                            state_nxt_s = HELD;
                            accept_s    = 1'b1;
                        end else begin
                            state_nxt_s = COUNT;
                        end
                    end else begin
                        cand_nxt_s  = cand_s;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = DIRECT_HELD ? HELD : COUNT;
                        accept_s    = DIRECT_HELD;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Debounce state and registered key outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cand_r      <= 4'd0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'd0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            cand_r      <= cand_nxt_s;
            key_valid_r <= accept_s;
            key_held_r  <= (state_nxt_s == HELD);
            if (accept_s) begin
                key_code_r <= cand_nxt_s;
            end
        end
    end

    assign col_n     = col_n_r;
    assign key_valid = key_valid_r;
    assign key_code  = key_code_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized frame-level stimulus for keypad_scanner, checked
// against a streak-counting model of the key-acceptance rules.
module tb_keypad_scanner;

    localparam int SC = 8;
    localparam int DF = 3;
    localparam int FRAME = 4 * SC;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] pressed;
    int          checks;
    int          failures;
    int          pulses;

    int          streak;
    int          streak_key;
    logic        exp_pulse;
    logic        exp_held;
    logic [3:0]  exp_code;
    logic [15:0] last_single;

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: key k pulls row k/4 low while column k%4 is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (col_n[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[r*4 + c]) row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        streak    = 0;
        streak_key = -1;
        exp_pulse = 1'b0;
        exp_held  = 1'b0;
        exp_code  = 4'd0;
    endtask

    // A key is accepted when it has been the only key seen for exactly DF frames in a row.
    task automatic model_frame(input logic [15:0] keys);
        int k;
        if ($countones(keys) == 1) begin
            k = $clog2(keys);
            if (streak > 0 && k == streak_key) begin
                if (streak < 1000) streak++;
            end else begin
                streak_key = k;
                streak = 1;
            end
            exp_pulse = (streak == DF);
            if (exp_pulse) exp_code = 4'(k);
        end else begin
            streak = 0;
            exp_pulse = 1'b0;
        end
        exp_held = (streak >= DF);
    endtask

    task automatic check_cycle(input int i);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << ((i / SC) % 4);
        check("col_n", {12'd0, col_n}, {12'd0, ~one_hot});
        check("key_valid", {15'd0, key_valid}, {15'd0, exp_pulse});
        check("key_held", {15'd0, key_held}, {15'd0, exp_held});
        check("key_code", {12'd0, key_code}, {12'd0, exp_code});
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic run_frame(input logic [15:0] keys);
        pressed = keys;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == FRAME) model_frame(keys);
            else exp_pulse = 1'b0;
            check_cycle(i);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_col_n"}, {12'd0, col_n}, 16'h000e);
        check({tag, "_valid"}, {15'd0, key_valid}, 16'h0000);
        check({tag, "_held"}, {15'd0, key_held}, 16'h0000);
        check({tag, "_code"}, {12'd0, key_code}, 16'h0000);
    endtask

    task automatic do_reset(input logic [15:0] keys_after);
        reset = 1'b1;
        pressed = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_reset_state("reset");
        reset = 1'b0;
        pressed = keys_after;
    endtask

    function automatic logic [15:0] key_bit(input int k);
        logic [15:0] v;
        v = 16'h0001;
        return v << k;
    endfunction

    initial begin
        logic [15:0] keys;
        int sel;
        checks = 0;
        failures = 0;
        pulses = 0;
        pressed = 16'h0000;
        model_reset();
        last_single = 16'h0000;

        // Scenario 1: idle scanning
        do_reset(16'h0000);
        pulses = 0;
        for (int f = 0; f < 10; f++) run_frame(16'h0000);
        check("s1_pulses", 16'(pulses), 16'd0);

        // Scenario 2: key 6 held from reset release
        do_reset(key_bit(6));
        pulses = 0;
        for (int f = 0; f < 12; f++) run_frame(key_bit(6));
        check("s2_pulses", 16'(pulses), 16'd1);
        check("s2_code", {12'd0, key_code}, 16'd6);

        // Scenario 3: bouncing key 6, then a clean release and re-press
        pulses = 0;
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 1) ? key_bit(6) : 16'h0000);
        check("s3_bounce_pulses", 16'(pulses), 16'd0);
        for (int f = 0; f < 3; f++) run_frame(16'h0000);
        for (int f = 0; f < 3; f++) run_frame(key_bit(6));
        check("s3_pulses", 16'(pulses), 16'd1);

        // Scenario 4: two-key chord rejected, then key 5 alone
        pulses = 0;
        for (int f = 0; f < 3; f++) run_frame(key_bit(0) | key_bit(5));
        check("s4_chord_pulses", 16'(pulses), 16'd0);
        for (int f = 0; f < 3; f++) run_frame(key_bit(5));
        check("s4_pulses", 16'(pulses), 16'd1);
        check("s4_code", {12'd0, key_code}, 16'd5);

        // Scenario 5: reset during a partially counted key 9
        pulses = 0;
        for (int f = 0; f < 2; f++) run_frame(key_bit(9));
        pressed = key_bit(9);
        exp_pulse = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(i);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_state("s5");
        pressed = 16'h0000;
        for (int f = 0; f < 2; f++) run_frame(16'h0000);
        check("s5_pulses", 16'(pulses), 16'd0);

        // Scenario 6: key 3 accepted, then switched straight to key 12
        pulses = 0;
        for (int f = 0; f < 4; f++) run_frame(key_bit(3));
        check("s6_first_code", {12'd0, key_code}, 16'd3);
        for (int f = 0; f < 4; f++) run_frame(key_bit(12));
        check("s6_pulses", 16'(pulses), 16'd2);
        check("s6_code", {12'd0, key_code}, 16'd12);

        // Randomized frames biased toward repeated single keys
        last_single = key_bit(12);
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 1) begin
                keys = 16'h0000;
            end else if (sel <= 5) begin
                keys = last_single;
            end else if (sel <= 7) begin
                keys = key_bit($urandom_range(0, 15));
                last_single = keys;
            end else begin
                keys = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
            end
            run_frame(keys);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
